// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       WE,
    input  logic [WIDTH-1:0]           write_data,
    input  logic                       RE,
    output logic [WIDTH-1:0]           read_data,
    output logic                       read_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic             wr_ok;
    logic             rd_ok;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    assign wr_ok = WE & ~full;
    assign rd_ok = RE & ~empty;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wp <= next_ptr(wp);
            end
            if (rd_ok) begin
                rp <= next_ptr(rp);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (WE && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (RE && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign read_data  = empty ? '0 : mem[rp];
    assign read_valid = ~empty;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_ok;
            if (rd_ok) begin
                read_data <= mem[rp];
            end
        end
    end
`endif

endmodule
